// File: rtl/bpu.sv
// Branch prediction unit: direct-mapped BTB with 2-bit saturating counters
// and a saturating mispredict counter for performance monitoring.
module bpu #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_mispredict_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              next_branch_o,
  output logic [31:0]       mispredict_cnt_o
);

  localparam int ENTRIES = 1 << IDX_W;

  logic              valid_r  [ENTRIES];
  logic [1:0]        ctr_r    [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [ADDR_W-1:0] target_r [ENTRIES];
  logic [31:0]       mispredict_cnt_r;

  logic [IDX_W-1:0]  lk_idx_s;
  logic              lk_hit_s;
  logic              pred_taken_s;
  logic [ADDR_W-1:0] pred_pc_s;
  logic [IDX_W-1:0]  up_idx_s;
  logic              up_hit_s;

  function automatic logic [IDX_W-1:0] get_idx(input logic [ADDR_W-1:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] pc);
    return pc[ADDR_W-1:IDX_W+2];
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Zero-latency lookup on registered table state (no write bypass)
  always_comb begin
    lk_idx_s     = get_idx(pc_i);
    lk_hit_s     = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == get_tag(pc_i));
    pred_taken_s = lk_hit_s && ctr_r[lk_idx_s][1];
    if (pred_taken_s) begin
      pred_pc_s = target_r[lk_idx_s];
    end else begin
      pred_pc_s = pc_i + ADDR_W'(4);
    end
  end

  assign next_pc_o     = pred_pc_s;
  assign next_branch_o = pred_taken_s;

  // Hit detection for the resolved instruction
  always_comb begin
    up_idx_s = get_idx(upd_pc_i);
    up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == get_tag(upd_pc_i));
  end

  // BTB training; a miss only allocates when the branch was taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        ctr_r[i]    <= 2'b01;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {ADDR_W{1'b0}};
      end
    end else if (upd_valid_i) begin
      if (up_hit_s) begin
        if (upd_taken_i) begin
          ctr_r[up_idx_s]    <= sat_inc(ctr_r[up_idx_s]);
          target_r[up_idx_s] <= upd_target_i;
        end else begin
          ctr_r[up_idx_s] <= sat_dec(ctr_r[up_idx_s]);
        end
      end else if (upd_taken_i) begin
        valid_r[up_idx_s]  <= 1'b1;
        tag_r[up_idx_s]    <= get_tag(upd_pc_i);
        target_r[up_idx_s] <= upd_target_i;
        ctr_r[up_idx_s]    <= 2'b10;
      end else begin
        valid_r[up_idx_s] <= valid_r[up_idx_s];
      end
    end else begin
      valid_r[0] <= valid_r[0];
    end
  end

  // Saturating mispredict counter, holds at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mispredict_cnt_r <= 32'd0;
    end else if (upd_valid_i && upd_mispredict_i && (mispredict_cnt_r != 32'hFFFF_FFFF)) begin
      mispredict_cnt_r <= mispredict_cnt_r + 32'd1;
    end else begin
      mispredict_cnt_r <= mispredict_cnt_r;
    end
  end

  assign mispredict_cnt_o = mispredict_cnt_r;

endmodule
